// File: rtl/raster_line_setup.sv
// rtl/raster_line_setup.sv - per-frame triangle edge setup and per-line edge stepping (optional second triangle: RASTER_SETUP_TRI2_EN)
module raster_line_setup (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic signed [19:0] x_screen_v0,
    input  logic signed [19:0] x_screen_v1,
    input  logic signed [19:0] x_screen_v2,
    input  logic signed [19:0] x_screen_v3,
    input  logic signed [19:0] y_screen_v0,
    input  logic signed [19:0] y_screen_v1,
    input  logic signed [19:0] y_screen_v2,
    input  logic signed [19:0] y_screen_v3,
    input  logic               vtx_valid,
    output logic signed [19:0] e0_init_t1,
    output logic signed [19:0] e1_init_t1,
    output logic signed [19:0] e2_init_t1,
    output logic signed [19:0] e0_init_t2,
    output logic signed [19:0] e1_init_t2,
    output logic signed [19:0] e2_init_t2,
    output logic               setup_busy,
    output logic               setup_done
);

`ifdef RASTER_SETUP_TRI2_EN
    localparam int         NE        = 6;
    localparam logic [3:0] LAST_PIDX = 4'd11;
`else
    localparam int         NE        = 3;
    localparam logic [3:0] LAST_PIDX = 4'd5;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_MUL, S_ACC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic signed [19:0] sx0_q, sx1_q, sx2_q, sy0_q, sy1_q, sy2_q;
    logic signed [19:0] sx0_d, sx1_d, sx2_d, sy0_d, sy1_d, sy2_d;
`ifdef RASTER_SETUP_TRI2_EN
    logic signed [19:0] sx3_q, sy3_q, sx3_d, sy3_d;
`else
    logic               unused_v3;
    assign unused_v3 = ^{x_screen_v3, y_screen_v3};
`endif
    logic [3:0]         pidx_q, pidx_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [19:0]        acc_q, acc_d;
    logic [19:0]        tmp_q, tmp_d;
    logic signed [19:0] work_q [NE];
    logic signed [19:0] work_d [NE];
    logic signed [19:0] e_q [NE];
    logic signed [19:0] e_d [NE];
    logic signed [19:0] delta [NE];

    logic [2:0]         edge_sel;
    logic signed [19:0] xa, ya, xb, yb;
    logic [19:0]        op_a, op_b, term, prod;

    logic start;
    logic line_step;
    assign start     = (y == 10'd524) && (x == 10'd0);
    assign line_step = (y < 10'd479) && (x == 10'd640);

    // Pick the edge endpoints for the current product and do one shift-add step (low 20 bits only)
    always_comb begin
        edge_sel = pidx_q[3:1];
        xa = sx0_q;
        ya = sy0_q;
        xb = sx1_q;
        yb = sy1_q;
        case (edge_sel)
            3'd1: begin xa = sx1_q; ya = sy1_q; xb = sx2_q; yb = sy2_q; end
            3'd2: begin xa = sx2_q; ya = sy2_q; xb = sx0_q; yb = sy0_q; end
`ifdef RASTER_SETUP_TRI2_EN
            3'd3: begin xa = sx0_q; ya = sy0_q; xb = sx2_q; yb = sy2_q; end
            3'd4: begin xa = sx2_q; ya = sy2_q; xb = sx3_q; yb = sy3_q; end
            3'd5: begin xa = sx3_q; ya = sy3_q; xb = sx0_q; yb = sy0_q; end
`endif
            default: ;
        endcase
        // even product: xA*(yB-yA); odd product: yA*(xB-xA)
        op_a = pidx_q[0] ? ya : xa;
        op_b = pidx_q[0] ? (xb - xa) : (yb - ya);
        term = op_b[cnt_q] ? (op_a << cnt_q) : 20'd0;
        prod = acc_q + term;
    end

    // Per-line increment of each edge value, taken from the latched vertices
    always_comb begin
        delta[0] = sx0_q - sx1_q;
        delta[1] = sx1_q - sx2_q;
        delta[2] = sx2_q - sx0_q;
`ifdef RASTER_SETUP_TRI2_EN
        delta[3] = sx0_q - sx2_q;
        delta[4] = sx2_q - sx3_q;
        delta[5] = sx3_q - sx0_q;
`endif
    end

    // Setup FSM next state, product sequencing and output update
    always_comb begin
        state_d = state_q;
        pidx_d  = pidx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        tmp_d   = tmp_q;
        sx0_d = sx0_q; sx1_d = sx1_q; sx2_d = sx2_q;
        sy0_d = sy0_q; sy1_d = sy1_q; sy2_d = sy2_q;
`ifdef RASTER_SETUP_TRI2_EN
        sx3_d = sx3_q; sy3_d = sy3_q;
`endif
        for (int k = 0; k < NE; k++) begin
            work_d[k] = work_q[k];
            e_d[k]    = line_step ? (e_q[k] + delta[k]) : e_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                    if (vtx_valid) begin
                        sx0_d = x_screen_v0; sx1_d = x_screen_v1; sx2_d = x_screen_v2;
                        sy0_d = y_screen_v0; sy1_d = y_screen_v1; sy2_d = y_screen_v2;
`ifdef RASTER_SETUP_TRI2_EN
                        sx3_d = x_screen_v3; sy3_d = y_screen_v3;
`endif
                    end
                end
            end
            S_LATCH: begin
                pidx_d  = 4'd0;
                cnt_d   = 5'd0;
                acc_d   = 20'd0;
                state_d = S_MUL;
            end
            S_MUL: begin
                acc_d = prod;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd19) begin
                    acc_d = 20'd0;
                    cnt_d = 5'd0;
                    if (!pidx_q[0]) begin
                        tmp_d = prod;
                    end else begin
                        // e(0,0) = yA*(xB-xA) - xA*(yB-yA)
                        for (int k = 0; k < NE; k++) begin
                            if (edge_sel == 3'(k)) begin
                                work_d[k] = prod - tmp_q;
                            end
                        end
                    end
                    if (pidx_q == LAST_PIDX) begin
                        state_d = S_ACC;
                    end else begin
                        pidx_d = pidx_q + 4'd1;
                    end
                end
            end
            S_ACC: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                for (int k = 0; k < NE; k++) begin
                    e_d[k] = work_q[k];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pidx_q  <= 4'd0;
            cnt_q   <= 5'd0;
            acc_q   <= 20'd0;
            tmp_q   <= 20'd0;
            sx0_q <= '0; sx1_q <= '0; sx2_q <= '0;
            sy0_q <= '0; sy1_q <= '0; sy2_q <= '0;
`ifdef RASTER_SETUP_TRI2_EN
            sx3_q <= '0; sy3_q <= '0;
`endif
            for (int k = 0; k < NE; k++) begin
                work_q[k] <= '0;
                e_q[k]    <= '0;
            end
        end else begin
            state_q <= state_d;
            pidx_q  <= pidx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            tmp_q   <= tmp_d;
            sx0_q <= sx0_d; sx1_q <= sx1_d; sx2_q <= sx2_d;
            sy0_q <= sy0_d; sy1_q <= sy1_d; sy2_q <= sy2_d;
`ifdef RASTER_SETUP_TRI2_EN
            sx3_q <= sx3_d; sy3_q <= sy3_d;
`endif
            for (int k = 0; k < NE; k++) begin
                work_q[k] <= work_d[k];
                e_q[k]    <= e_d[k];
            end
        end
    end

    assign e0_init_t1 = e_q[0];
    assign e1_init_t1 = e_q[1];
    assign e2_init_t1 = e_q[2];
`ifdef RASTER_SETUP_TRI2_EN
    assign e0_init_t2 = e_q[3];
    assign e1_init_t2 = e_q[4];
    assign e2_init_t2 = e_q[5];
`else
    assign e0_init_t2 = '0;
    assign e1_init_t2 = '0;
    assign e2_init_t2 = '0;
`endif
    assign setup_busy = (state_q != S_IDLE);
    assign setup_done = (state_q == S_DONE);

endmodule

// File: tb/tb_raster_line_setup.sv
// tb/tb_raster_line_setup.sv - scoreboard bench for raster_line_setup
module tb_raster_line_setup;

    localparam int K_DONE = 0;
    localparam int K_LINE = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         x, y;
    logic signed [19:0] xv0, xv1, xv2, xv3, yv0, yv1, yv2, yv3;
    logic               vtx_valid;
    logic signed [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
    logic signed [19:0] e0_init_t2, e1_init_t2, e2_init_t2;
    logic               setup_busy, setup_done;

    int checks = 0;
    int errors = 0;
    bit done_pending = 1'b0;

    typedef struct {
        int               kind;
        int               yl;
        logic [5:0][19:0] ev;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    raster_line_setup dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .x_screen_v0(xv0), .x_screen_v1(xv1), .x_screen_v2(xv2), .x_screen_v3(xv3),
        .y_screen_v0(yv0), .y_screen_v1(yv1), .y_screen_v2(yv2), .y_screen_v3(yv3),
        .vtx_valid(vtx_valid),
        .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
        .e0_init_t2(e0_init_t2), .e1_init_t2(e1_init_t2), .e2_init_t2(e2_init_t2),
        .setup_busy(setup_busy), .setup_done(setup_done)
    );

    // Edge value at (0, steps) computed at full width, then wrapped to 20 bits
    function automatic logic [19:0] ref_e(input longint xa, input longint ya,
                                          input longint xb, input longint yb,
                                          input longint steps);
        longint v;
        v = -(xa * (yb - ya)) + ya * (xb - xa) + steps * (xa - xb);
        return v[19:0];
    endfunction

    task automatic check(input string nm, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic push(input int kind, input int yl, input int a, input int b, input int c,
                        input logic [19:0] d, input logic [19:0] e, input logic [19:0] f);
        exp_t t;
        t.kind  = kind;
        t.yl    = yl;
        t.ev[0] = 20'(a);
        t.ev[1] = 20'(b);
        t.ev[2] = 20'(c);
`ifdef RASTER_SETUP_TRI2_EN
        t.ev[3] = d;
        t.ev[4] = e;
        t.ev[5] = f;
`else
        t.ev[3] = 20'd0;
        t.ev[4] = 20'd0;
        t.ev[5] = 20'd0;
        if (d == e && e == f && d != d) t.ev[3] = 20'd0;
`endif
        sb.push_back(t);
    endtask

    task automatic cmp(input exp_t t, input string tag);
        logic [5:0][19:0] a;
        a = {e2_init_t2, e1_init_t2, e0_init_t2, e2_init_t1, e1_init_t1, e0_init_t1};
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_y%0d_e%0d", tag, t.yl, i), a[i] == t.ev[i],
                  longint'($signed(a[i])), longint'($signed(t.ev[i])));
        end
    endtask

    // Monitor: consume expectations when the DUT presents a setup result or a stepped line
    initial begin
        forever begin
            @(negedge clk);
            if (done_pending) begin
                done_pending = 1'b0;
                if (sb.size() == 0 || sb[0].kind != K_DONE) begin
                    check("unexpected_setup_done", 1'b0, 1, 0);
                end else begin
                    cmp(sb[0], "done");
                    void'(sb.pop_front());
                end
            end
            if (setup_done && reset) done_pending = 1'b1;
            if (sb.size() > 0 && sb[0].kind == K_LINE && x == 10'd641 && y == 10'(sb[0].yl)) begin
                cmp(sb[0], "line");
                void'(sb.pop_front());
            end
`ifndef RASTER_SETUP_TRI2_EN
            check("t2_tied_zero", {e0_init_t2, e1_init_t2, e2_init_t2} == 60'd0,
                  longint'(e0_init_t2) | longint'(e1_init_t2) | longint'(e2_init_t2), 0);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic set_vtx(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3);
        xv0 = 20'(x0); yv0 = 20'(y0);
        xv1 = 20'(x1); yv1 = 20'(y1);
        xv2 = 20'(x2); yv2 = 20'(y2);
        xv3 = 20'(x3); yv3 = 20'(y3);
    endtask

    task automatic drive(input int xn, input int yn);
        @(posedge clk);
        #1;
        x = 10'(xn);
        y = 10'(yn);
    endtask

    task automatic do_line(input int yn);
        drive(639, yn);
        drive(640, yn);
        drive(641, yn);
    endtask

    // One y==524 line: start, optional reset pulse at reset_at, latency and busy checks
    task automatic run_frame(input int reset_at, input bit expect_done);
        int d;
        d = -1;
        for (int xn = 0; xn < 800; xn++) begin
            @(posedge clk);
            #1;
            if (!reset) reset = 1'b1;
            x = 10'(xn);
            y = 10'd524;
            if (xn == reset_at) begin
                #1 reset = 1'b0;
                #1;
                check("rst_mid_e0_t1", e0_init_t1 == 0, e0_init_t1, 0);
                check("rst_mid_e1_t1", e1_init_t1 == 0, e1_init_t1, 0);
                check("rst_mid_e2_t1", e2_init_t1 == 0, e2_init_t1, 0);
                check("rst_mid_busy", setup_busy == 1'b0, setup_busy, 0);
            end
            @(negedge clk);
            if (setup_done && d < 0) d = xn;
            if (xn == 0) check("busy_before_latch", setup_busy == 1'b0, setup_busy, 0);
            if (xn == 1) check("busy_in_latch", setup_busy == 1'b1, setup_busy, 1);
        end
        check("busy_idle_end", setup_busy == 1'b0, setup_busy, 0);
        if (expect_done) check("done_within_300", d >= 2 && d <= 301, d, 301);
        else             check("no_done_after_reset", d == -1, d, -1);
    endtask

    initial begin
        reset     = 1'b0;
        x         = 10'd0;
        y         = 10'd524;
        vtx_valid = 1'b1;
        set_vtx(100, 50, 300, 60, 200, 250, 50, 200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_e0_t1", e0_init_t1 == 0, e0_init_t1, 0);
        check("rst_e1_t1", e1_init_t1 == 0, e1_init_t1, 0);
        check("rst_e2_t1", e2_init_t1 == 0, e2_init_t1, 0);
        check("rst_busy", setup_busy == 1'b0, setup_busy, 0);
        check("rst_done", setup_done == 1'b0, setup_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        x = 10'd5;
        y = 10'd0;

        // frame 1: reference triangle
        push(K_DONE, 524, 9000, -63000, 15000,
             ref_e(100, 50, 200, 250, 0), ref_e(200, 250, 50, 200, 0), ref_e(50, 200, 100, 50, 0));
        run_frame(-1, 1'b1);
        set_vtx(7, 11, 400, 3, 12, 300, 9, 9);
        push(K_LINE, 0, 8800, -62900, 15100,
             ref_e(100, 50, 200, 250, 1), ref_e(200, 250, 50, 200, 1), ref_e(50, 200, 100, 50, 1));
        push(K_LINE, 478, 9000 - 479 * 200, -63000 + 479 * 100, 15000 + 479 * 100,
             ref_e(100, 50, 200, 250, 479), ref_e(200, 250, 50, 200, 479), ref_e(50, 200, 100, 50, 479));
        push(K_LINE, 479, 9000 - 479 * 200, -63000 + 479 * 100, 15000 + 479 * 100,
             ref_e(100, 50, 200, 250, 479), ref_e(200, 250, 50, 200, 479), ref_e(50, 200, 100, 50, 479));
        push(K_LINE, 500, 9000 - 479 * 200, -63000 + 479 * 100, 15000 + 479 * 100,
             ref_e(100, 50, 200, 250, 479), ref_e(200, 250, 50, 200, 479), ref_e(50, 200, 100, 50, 479));
        for (int yn = 0; yn <= 479; yn++) do_line(yn);
        do_line(500);

        // frame 2: vertices invalid, shadow values reused
        vtx_valid = 1'b0;
        push(K_DONE, 524, 9000, -63000, 15000,
             ref_e(100, 50, 200, 250, 0), ref_e(200, 250, 50, 200, 0), ref_e(50, 200, 100, 50, 0));
        run_frame(-1, 1'b1);
        push(K_LINE, 0, 8800, -62900, 15100,
             ref_e(100, 50, 200, 250, 1), ref_e(200, 250, 50, 200, 1), ref_e(50, 200, 100, 50, 1));
        do_line(0);

        // frame 3: reset 50 clocks into the multiply phase
        vtx_valid = 1'b1;
        set_vtx(100, 50, 300, 60, 200, 250, 50, 200);
        run_frame(52, 1'b0);

        // frame 4: full setup after the aborted one
        push(K_DONE, 524, 9000, -63000, 15000,
             ref_e(100, 50, 200, 250, 0), ref_e(200, 250, 50, 200, 0), ref_e(50, 200, 100, 50, 0));
        run_frame(-1, 1'b1);
        push(K_LINE, 0, 8800, -62900, 15100,
             ref_e(100, 50, 200, 250, 1), ref_e(200, 250, 50, 200, 1), ref_e(50, 200, 100, 50, 1));
        do_line(0);

        // frame 5: extreme coordinates, wrapped arithmetic
        set_vtx(-524288, 0, 524287, 0, 0, 1, 0, 0);
        push(K_DONE, 524, 0, -524287, -524288,
             ref_e(-524288, 0, 0, 1, 0), ref_e(0, 1, 0, 0, 0), ref_e(0, 0, -524288, 0, 0));
        run_frame(-1, 1'b1);
        push(K_LINE, 0, 1, 0, 0,
             ref_e(-524288, 0, 0, 1, 1), ref_e(0, 1, 0, 0, 1), ref_e(0, 0, -524288, 0, 1));
        do_line(0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/raster_line_setup.md
RASTER_LINE_SETUP -- requirements
Module: raster_line_setup

Interface
REQ-001 clk  in  1  single system clock (pixel clock); all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-003 x, y  in  10 each  VGA counters (x 0..799, y 0..524).
REQ-004 x_screen_v0..v3, y_screen_v0..v3  in  signed 20 each  vertex screen coords from VS.
REQ-005 vtx_valid  in  1  high = vertex set stable and usable this frame.
REQ-006 e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2  out  signed 20 each  edge values at pixel (0, current line+1), registered.
REQ-007 setup_busy  out  1  frame setup in progress; setup_done  out  1  one-cycle pulse at setup completion.

Function
REQ-008 Edges: t1 = (v0->v1, v1->v2, v2->v0); t2 = (v0->v2, v2->v3, v3->v0); edge A->B value e(px,py) = (px-xA)*(yB-yA) - (py-yA)*(xB-xA).
REQ-009 Arithmetic is modulo 2^20 two's complement throughout: differences, products (low 20 bits of signed product), sums; no saturation.
REQ-010 Latch: at y==524 and x==0, if vtx_valid=1 copy all 8 vertex coords into shadow registers; if vtx_valid=0 keep previous shadow values; setup starts in both cases.
REQ-011 FSM states: IDLE -> LATCH (1 cycle) -> MUL (sequential, one shared 20x20 shift-add multiplier) -> ACC -> DONE (1 cycle, setup_done=1) -> IDLE.
REQ-012 MUL computes, per edge in order t1e0,t1e1,t1e2,t2e0,t2e1,t2e2, e(0,0) = -xA*(yB-yA) + yA*(xB-xA): 12 products total.
REQ-013 Setup shall finish (setup_done pulse) no later than 300 clocks after the LATCH cycle, i.e. before y==524, x==799.
REQ-014 On DONE, all six outputs load line-0 values simultaneously; outputs never show partial results during MUL.
REQ-015 Per-line step: in the cycle where y<479 and x==640, each output adds its delta (xA-xB) for its edge; no step at any other x/y.
REQ-016 Deltas are computed from shadow registers, so vertex input changes mid-frame have no effect until the next latch.
REQ-017 setup_busy=1 from LATCH through DONE inclusive, else 0.
REQ-018 A start condition arriving while busy (not reachable with legal counters) shall be ignored.
REQ-019 Outputs hold their value in all cycles not named in REQ-014/REQ-015.

Reset
REQ-020 While reset=0: all outputs 0, setup_busy=0, setup_done=0, shadow registers 0, FSM IDLE.
REQ-021 Reset asserted mid-setup aborts it; after release the block waits in IDLE for the next y==524, x==0.

Configuration
REQ-022 Macro RASTER_SETUP_TRI2_EN: defined -> t2 edges computed and stepped as above (12 products).
REQ-023 Not defined -> t2 outputs tied to constant 0, only 6 products computed, v3 shadow registers omitted; t1 behaviour and timing bound unchanged.

Verification
REQ-024 v0=(100,50), v1=(300,60), v2=(200,250), vtx_valid=1, run to y==524, x==799 -> e0/e1/e2_init_t1 = 9000 / -63000 / 15000.
REQ-025 Same frame, after y==0, x==640 -> 8800 / -62900 / 15100; after y==478, x==640 -> 9000-479*200 / -63000+479*100 / 15000+479*100, each mod 2^20.
REQ-026 Frame 2 with vtx_valid=0 and different vertex inputs -> line-0 outputs identical to REQ-024 values.
REQ-027 reset pulsed low at 50 clocks into MUL -> outputs 0 immediately, no setup_done that frame, correct values after the next full setup.
REQ-028 v0=(-524288,0), v1=(524287,0), v2=(0,1) -> wrapped 20-bit results match a modulo-2^20 reference model; setup_done within 300 clocks.
REQ-029 Build without RASTER_SETUP_TRI2_EN -> t2 outputs 0 for all cycles; t1 results as in REQ-024/REQ-025.
